// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, attribute field layout and clear FSM states for the sprite attribute RAM
package sprite_pkg;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_NBYTES  = 6;
  localparam int X_LSB       = 0;
  localparam int X_W         = 10;
  localparam int VFLIP_BIT   = 10;
  localparam int HFLIP_BIT   = 11;
  localparam int PAL_OFS_LSB = 12;
  localparam int PAL_OFS_W   = 4;
  localparam int Y_LSB       = 16;
  localparam int Y_W         = 9;
  localparam int MODE_BIT    = 25;
  localparam int Z_LSB       = 26;
  localparam int Z_W         = 2;
  localparam int HEIGHT_LSB  = 28;
  localparam int HEIGHT_W    = 2;
  localparam int WIDTH_LSB   = 30;
  localparam int WIDTH_W     = 2;
  localparam int ADDR_LSB    = 32;
  localparam int ADDR_W      = 16;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/sprite_attr_ram_mem.sv
// sprite_attr_ram_mem: simple dual-port array with per-lane write enables and a registered, enabled read
module sprite_attr_ram_mem
  import sprite_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int NL    = DEF_NBYTES,
  parameter int LW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [NL-1:0]    we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [NL*LW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [NL*LW-1:0] rdata_o
);
  logic [NL*LW-1:0] mem_q [DEPTH];
  // Per-lane write so only enabled lanes change
  always_ff @(posedge clk) begin
    for (int k = 0; k < NL; k++)
      if (we_i[k]) mem_q[waddr_i][k*LW +: LW] <= wdata_i[k*LW +: LW];
  end
  // Read register only loads on a read so the output holds between reads
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/sprite_attr_ram.sv
// sprite_attr_ram: sprite attribute RAM with clear sweep, byte writes, forwarding; optional parity via SPRITE_ATTR_PARITY_EN
module sprite_attr_ram
  import sprite_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NBYTES = DEF_NBYTES,
  localparam int AW    = $clog2(DEPTH),
  localparam int W     = 8*NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  output logic              busy_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [NBYTES-1:0] ben_i,
  input  logic [W-1:0]      wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [W-1:0]      rd_data_o,
  output logic              rd_valid_o,
  output logic              par_err_o
);
`ifdef SPRITE_ATTR_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int SW = NBYTES*LW;
  clr_state_t state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic busy, wr_acc, rd_valid_q, zero_q;
  logic [NBYTES-1:0] mem_we, fwd_q;
  logic [AW-1:0] mem_waddr;
  logic [SW-1:0] bus_lanes, mem_wdata, mem_rdata, fwd_data_q, rd_lanes;
  assign busy = state_q == CLEAR;
  assign busy_o = busy;
  assign rd_valid_o = rd_valid_q;
  assign wr_acc = wr_en_i & ~busy & ~clear_i;
  // Sweep advances one entry per cycle; clear_i always restarts at entry 0
  always_comb begin
    state_d = clear_i ? CLEAR : (busy && clr_addr_q == AW'(DEPTH-1)) ? IDLE : state_q;
    clr_addr_d = (busy && !clear_i) ? clr_addr_q + AW'(1) : '0;
  end
  // Clear FSM state register; reset starts a fresh sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
`ifdef SPRITE_ATTR_PARITY_EN
    assign bus_lanes[k*LW +: LW] = {^wr_data_i[8*k +: 8], wr_data_i[8*k +: 8]};
`else
    assign bus_lanes[k*LW +: LW] = wr_data_i[8*k +: 8];
`endif
    assign rd_lanes[k*LW +: LW] = zero_q ? '0 : fwd_q[k] ? fwd_data_q[k*LW +: LW] : mem_rdata[k*LW +: LW];
    assign rd_data_o[8*k +: 8] = rd_lanes[k*LW +: 8];
  end
  assign mem_we = busy ? '1 : wr_acc ? ben_i : '0;
  assign mem_waddr = busy ? clr_addr_q : wr_addr_i;
  assign mem_wdata = busy ? '0 : bus_lanes;
  sprite_attr_ram_mem #(.DEPTH(DEPTH), .NL(NBYTES), .LW(LW)) u_mem (
    .clk(clk),
    .we_i(mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i(rd_en_i),
    .raddr_i(rd_addr_i),
    .rdata_o(mem_rdata)
  );
  // Capture read context: sweep-zeroing and which lanes come from a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      zero_q <= 1'b1;
      fwd_q <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        zero_q <= busy;
        fwd_q <= (wr_acc && wr_addr_i == rd_addr_i) ? ben_i : '0;
        fwd_data_q <= bus_lanes;
      end
    end
  end
`ifdef SPRITE_ATTR_PARITY_EN
  logic par_err_q, mism;
  // Any lane with odd parity on the delivered word is an error
  always_comb begin
    mism = 1'b0;
    for (int k = 0; k < NBYTES; k++) mism = mism | ^rd_lanes[k*LW +: LW];
  end
  // Sticky error flag, cleared by reset or a new sweep
  always_ff @(posedge clk) begin
    if (rst || clear_i) par_err_q <= 1'b0;
    else par_err_q <= par_err_q | (rd_valid_q & mism);
  end
  assign par_err_o = par_err_q | (rd_valid_q & mism);
`else
  assign par_err_o = 1'b0;
`endif
endmodule
